// File: rtl/serial_byte_loader.sv
// Serial-to-parallel loader: assembles BIT_COUNT serial bits, then issues one store pulse for a latch array.
// Latency: data_out and store update on the edge that accepts the last bit; done follows one edge later, IDLE one edge after that.
// Backpressure: bit_valid=0 stalls SHIFT indefinitely; start is ignored (not queued) while busy.
module serial_byte_loader #(
  parameter int BIT_COUNT = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               start,
  input  logic                               serial_in,
  input  logic                               bit_valid,
  input  logic                               abort,
  output logic [BIT_COUNT-1:0]               data_out,
  output logic                               store,
  output logic                               busy,
  output logic                               done,
  output logic [$clog2(BIT_COUNT+1)-1:0]     bit_count
);

  localparam int CW = $clog2(BIT_COUNT + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, STORE, HOLD} state_t;

  state_t               state;
  logic [BIT_COUNT-1:0] shreg;
  logic [BIT_COUNT-1:0] shreg_nxt;
  logic                 last_bit;

  // Next shift-register value with the incoming bit inserted at the configured end.
  always_comb begin
    shreg_nxt = shreg;
    if (MSB_FIRST) begin
      shreg_nxt = {shreg[BIT_COUNT-2:0], serial_in};
    end else begin
      shreg_nxt = {serial_in, shreg[BIT_COUNT-1:1]};
    end
    last_bit = (bit_count == CW'(BIT_COUNT - 1));
  end

  // Frame FSM; every output is a register so the latch array sees glitch-free store and data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      shreg     <= '0;
      data_out  <= '0;
      store     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      bit_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          store     <= 1'b0;
          done      <= 1'b0;
          bit_count <= '0;
          busy      <= 1'b0;
          if (start) begin
            shreg <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (abort) begin
            // Drop the partial frame; data_out keeps the previous word.
            bit_count <= '0;
            busy      <= 1'b0;
            state     <= IDLE;
          end else if (bit_valid) begin
            shreg     <= shreg_nxt;
            bit_count <= bit_count + 1'b1;
            if (last_bit) begin
              data_out <= shreg_nxt;
              store    <= 1'b1;
              state    <= STORE;
            end
          end
        end
        STORE: begin
          // Single-cycle pulse; data_out stays put through the following HOLD cycle.
          store <= 1'b0;
          done  <= 1'b1;
          state <= HOLD;
        end
        HOLD: begin
          done      <= 1'b0;
          busy      <= 1'b0;
          bit_count <= '0;
          state     <= IDLE;
        end
        default: begin
          store     <= 1'b0;
          done      <= 1'b0;
          busy      <= 1'b0;
          bit_count <= '0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_byte_loader.sv
// Bench for serial_byte_loader: MSB-first and LSB-first instances share one stimulus stream.
// Expected words are queued when the last bit is driven; a negedge monitor pops them on store.
// Status (busy/done/bit_count) is compared against the frame-level protocol after every edge.
module tb_serial_byte_loader;

  logic       clk = 1'b0;
  logic       rst_n, start, serial_in, bit_valid, abort;
  logic [7:0] d_m, d_l;
  logic       store_m, store_l, busy_m, busy_l, done_m, done_l;
  logic [3:0] bc_m, bc_l;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] qm[$];
  logic [7:0] ql[$];
  logic [7:0] cur_m = 8'h00, cur_l = 8'h00;
  logic       sp_m = 1'b0, sp_l = 1'b0;
  logic       rst_q = 1'b0;
  logic       mon_en = 1'b0;

  always #5 clk = ~clk;

  serial_byte_loader #(.BIT_COUNT(8), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst_n(rst_n), .start(start), .serial_in(serial_in),
    .bit_valid(bit_valid), .abort(abort), .data_out(d_m), .store(store_m),
    .busy(busy_m), .done(done_m), .bit_count(bc_m)
  );

  serial_byte_loader #(.BIT_COUNT(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst_n(rst_n), .start(start), .serial_in(serial_in),
    .bit_valid(bit_valid), .abort(abort), .data_out(d_l), .store(store_l),
    .busy(busy_l), .done(done_l), .bit_count(bc_l)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // First received bit is the most significant.
  function automatic logic [7:0] msb_word(input logic [7:0] seq);
    int w = 0;
    for (int i = 0; i < 8; i++) w = w * 2 + int'(seq[i]);
    return 8'(w);
  endfunction

  // First received bit is the least significant.
  function automatic logic [7:0] lsb_word(input logic [7:0] seq);
    int w = 0;
    for (int i = 0; i < 8; i++) if (seq[i]) w = w + (1 << i);
    return 8'(w);
  endfunction

  function automatic logic nz(input int noise);
    if (noise == 2) return 1'b1;
    if (noise == 1) return 1'($urandom);
    return 1'b0;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic st_chk(input string nm, input logic eb, input logic ed, input logic [3:0] ebc);
    chk({nm, "_msb"}, {busy_m, done_m, bc_m}, {eb, ed, ebc});
    chk({nm, "_lsb"}, {busy_l, done_l, bc_l}, {eb, ed, ebc});
  endtask

  // seq[i] is the i-th bit sent; stall_at/abort_at index the bit before which they happen.
  task automatic frame(input logic [7:0] seq, input int stall_at, input int stall_n,
                       input int abort_at, input int noise);
    start = 1'b1; bit_valid = 1'($urandom); serial_in = 1'($urandom);
    abort = (noise != 0) ? 1'($urandom) : 1'b0;
    tick;
    start = 1'b0; abort = 1'b0;
    st_chk("after_start", 1'b1, 1'b0, 4'd0);
    for (int i = 0; i < 8; i++) begin
      if (i == stall_at) begin
        for (int s = 0; s < stall_n; s++) begin
          bit_valid = 1'b0; serial_in = 1'($urandom); start = nz(noise);
          tick;
          st_chk("stall", 1'b1, 1'b0, 4'(i));
        end
      end
      if (i == abort_at) begin
        abort = 1'b1; bit_valid = 1'($urandom); serial_in = 1'($urandom); start = nz(noise);
        tick;
        abort = 1'b0; bit_valid = 1'b0; start = 1'b0;
        st_chk("abort", 1'b0, 1'b0, 4'd0);
        return;
      end
      if (i == 7) begin
        qm.push_back(msb_word(seq));
        ql.push_back(lsb_word(seq));
      end
      bit_valid = 1'b1; serial_in = seq[i]; start = nz(noise);
      tick;
      st_chk("shift", 1'b1, 1'b0, 4'(i + 1));
    end
    bit_valid = 1'($urandom); serial_in = 1'($urandom); start = nz(noise);
    abort = (noise != 0) ? 1'($urandom) : 1'b0;
    tick;
    st_chk("hold", 1'b1, 1'b1, 4'd8);
    bit_valid = 1'($urandom); start = nz(noise); abort = 1'b0;
    tick;
    st_chk("idle", 1'b0, 1'b0, 4'd0);
    start = 1'b0; bit_valid = 1'b0; abort = 1'b0;
  endtask

  always @(posedge clk) rst_q = rst_n;

  // Monitor: pops the expected word on each store and tracks data_out and pulse shape every cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      if (!rst_q) begin
        cur_m = 8'h00; cur_l = 8'h00; sp_m = 1'b0; sp_l = 1'b0;
        chk("rst_store_msb", store_m, 1'b0);
        chk("rst_store_lsb", store_l, 1'b0);
        chk("rst_done_msb", done_m, 1'b0);
        chk("rst_done_lsb", done_l, 1'b0);
      end else begin
        if (store_m) begin
          chk("store_expected_msb", 32'(qm.size() > 0), 32'd1);
          if (qm.size() > 0) cur_m = qm.pop_front();
        end
        if (store_l) begin
          chk("store_expected_lsb", 32'(ql.size() > 0), 32'd1);
          if (ql.size() > 0) cur_l = ql.pop_front();
        end
        chk("done_after_store_msb", done_m, sp_m);
        chk("done_after_store_lsb", done_l, sp_l);
        chk("store_double_msb", store_m & sp_m, 1'b0);
        chk("store_double_lsb", store_l & sp_l, 1'b0);
      end
      chk("data_msb", d_m, cur_m);
      chk("data_lsb", d_l, cur_l);
      sp_m = store_m;
      sp_l = store_l;
    end
  end

  initial begin
    logic [7:0] seq;
    int stall_at, stall_n, abort_at;

    // Reset with random inputs for two edges.
    rst_n = 1'b0; start = 1'($urandom); serial_in = 1'($urandom);
    bit_valid = 1'($urandom); abort = 1'($urandom);
    tick;
    mon_en = 1'b1;
    start = 1'($urandom); serial_in = 1'($urandom); bit_valid = 1'($urandom); abort = 1'($urandom);
    tick;
    st_chk("reset", 1'b0, 1'b0, 4'd0);
    chk("reset_data_msb", d_m, 8'h00);
    chk("reset_data_lsb", d_l, 8'h00);
    chk("reset_store_msb", store_m, 1'b0);
    rst_n = 1'b1; start = 1'b0; bit_valid = 1'b0; abort = 1'b0;
    tick;

    // Bits 1,1,0,1,0,0,0,0 in order.
    seq = 8'b0000_1011;
    frame(seq, -1, 0, -1, 0);
    chk("dir_msb", d_m, 8'hD0);
    chk("dir_lsb", d_l, 8'h0B);

    // Same bits with a 3-cycle stall after the fourth bit.
    frame(seq, 4, 3, -1, 0);
    chk("stall_msb", d_m, 8'hD0);
    chk("stall_lsb", d_l, 8'h0B);

    // Abort after five bits: previous word must survive.
    frame(8'($urandom), -1, 0, 5, 0);
    chk("abort_keep_msb", d_m, 8'hD0);
    chk("abort_keep_lsb", d_l, 8'h0B);
    tick;

    // Reset after six bits, then a full all-ones frame.
    start = 1'b1; tick; start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bit_valid = 1'b1; serial_in = 1'($urandom); tick;
    end
    bit_valid = 1'b1; rst_n = 1'b0; tick;
    rst_n = 1'b1; bit_valid = 1'b0;
    st_chk("midrst", 1'b0, 1'b0, 4'd0);
    chk("midrst_data_msb", d_m, 8'h00);
    chk("midrst_data_lsb", d_l, 8'h00);
    frame(8'hFF, -1, 0, -1, 0);
    chk("ones_msb", d_m, 8'hFF);
    chk("ones_lsb", d_l, 8'hFF);

    // start held high through SHIFT, STORE and the done cycle, then a back-to-back frame.
    frame(8'b1010_0110, 2, 2, -1, 2);
    frame(8'b0011_1001, -1, 0, -1, 0);

    // Randomized frames with stalls, aborts and ignored control noise.
    for (int f = 0; f < 40; f++) begin
      seq      = 8'($urandom);
      stall_at = $urandom_range(0, 8);
      stall_n  = $urandom_range(0, 3);
      abort_at = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 7) : -1;
      frame(seq, stall_at, stall_n, abort_at, 1);
      for (int g = $urandom_range(0, 2); g > 0; g--) begin
        bit_valid = 1'($urandom); serial_in = 1'($urandom); abort = 1'($urandom);
        tick;
        st_chk("gap", 1'b0, 1'b0, 4'd0);
      end
      bit_valid = 1'b0; abort = 1'b0;
    end

    tick; tick; tick;
    chk("queue_empty_msb", qm.size(), 32'd0);
    chk("queue_empty_lsb", ql.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
